// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multicycle MIPS control FSM with memory handshake and a saturating retired-instruction counter.
module mips_mc_ctrl #(
  parameter bit EN_BNE  = 1'b1,
  parameter bit EN_ADDI = 1'b1,
  parameter bit EN_J    = 1'b1,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       Opcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             IorD,
  output logic             IRWrite,
  output logic             MemWrite,
  output logic             PCWrite,
  output logic             Branch,
  output logic             BranchNe,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSrc,
  output logic [3:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3, MEMWB = 4'd4,
    MEMWRITE = 4'd5, EXECUTE = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8, ADDIEX = 4'd9,
    ADDIWB = 4'd10, JUMP = 4'd11, HALT = 4'd15
  } state_t;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000,
                         OP_J = 6'b000010;
  state_t state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic retire;
  always_comb begin
    state_d  = state_q;
    mem_req  = 1'b0;
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    MemWrite = 1'b0;
    PCWrite  = 1'b0;
    Branch   = 1'b0;
    BranchNe = 1'b0;
    RegWrite = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    PCSrc    = 2'b00;
    case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        state_d = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        state_d = (Opcode == OP_LW || Opcode == OP_SW) ? MEMADR :
                  (Opcode == OP_R)                     ? EXECUTE :
                  (Opcode == OP_BEQ)                   ? BRANCH :
                  (EN_BNE && Opcode == OP_BNE)         ? BRANCH :
                  (EN_ADDI && Opcode == OP_ADDI)       ? ADDIEX :
                  (EN_J && Opcode == OP_J)             ? JUMP : HALT;
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (Opcode == OP_SW) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        IorD    = 1'b1;
        state_d = mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        state_d  = FETCH;
      end
      MEMWRITE: begin
        mem_req  = 1'b1;
        IorD     = 1'b1;
        MemWrite = 1'b1;
        state_d  = mem_ready ? FETCH : MEMWRITE;
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = ALUWB;
      end
      ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        state_d  = FETCH;
      end
      BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 2'b01;
        PCSrc    = 2'b01;
        Branch   = (Opcode == OP_BEQ);
        BranchNe = EN_BNE && (Opcode == OP_BNE);
        state_d  = FETCH;
      end
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = ADDIWB;
      end
      ADDIWB: begin
        RegWrite = 1'b1;
        state_d  = FETCH;
      end
      JUMP: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
        state_d = FETCH;
      end
      default: state_d = HALT;
    endcase
  end
  // Every completing state returns straight to FETCH, so retirement is any non-FETCH/DECODE entry into FETCH.
  assign retire    = (state_d == FETCH) && (state_q inside {MEMWB, MEMWRITE, ALUWB, BRANCH, ADDIWB, JUMP});
  assign retired_d = (retire && retired_q != '1) ? retired_q + CNT_W'(1) : retired_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end
  assign state   = state_q;
  assign halted  = (state_q == HALT);
  assign retired = retired_q;
endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb_mips_mc_ctrl: table-driven instruction walk on a default controller plus hand sequences on an EN_BNE=0, CNT_W=4 copy.
module tb_mips_mc_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic [5:0] op;
  logic rdy;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;

  logic mem_req_a, IorD_a, IRWrite_a, MemWrite_a, PCWrite_a, Branch_a, BranchNe_a;
  logic RegWrite_a, RegDst_a, MemtoReg_a, ALUSrcA_a, halted_a;
  logic [1:0] ALUSrcB_a, ALUOp_a, PCSrc_a;
  logic [3:0] state_a;
  logic [31:0] retired_a;
  logic mem_req_b, IorD_b, IRWrite_b, MemWrite_b, PCWrite_b, Branch_b, BranchNe_b;
  logic RegWrite_b, RegDst_b, MemtoReg_b, ALUSrcA_b, halted_b;
  logic [1:0] ALUSrcB_b, ALUOp_b, PCSrc_b;
  logic [3:0] state_b;
  logic [3:0] retired_b;

  mips_mc_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .Opcode(op), .mem_ready(rdy),
    .mem_req(mem_req_a), .IorD(IorD_a), .IRWrite(IRWrite_a), .MemWrite(MemWrite_a),
    .PCWrite(PCWrite_a), .Branch(Branch_a), .BranchNe(BranchNe_a), .RegWrite(RegWrite_a),
    .RegDst(RegDst_a), .MemtoReg(MemtoReg_a), .ALUSrcA(ALUSrcA_a), .ALUSrcB(ALUSrcB_a),
    .ALUOp(ALUOp_a), .PCSrc(PCSrc_a), .state(state_a), .halted(halted_a), .retired(retired_a)
  );
  mips_mc_ctrl #(.EN_BNE(1'b0), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .Opcode(op), .mem_ready(rdy),
    .mem_req(mem_req_b), .IorD(IorD_b), .IRWrite(IRWrite_b), .MemWrite(MemWrite_b),
    .PCWrite(PCWrite_b), .Branch(Branch_b), .BranchNe(BranchNe_b), .RegWrite(RegWrite_b),
    .RegDst(RegDst_b), .MemtoReg(MemtoReg_b), .ALUSrcA(ALUSrcA_b), .ALUSrcB(ALUSrcB_b),
    .ALUOp(ALUOp_b), .PCSrc(PCSrc_b), .state(state_b), .halted(halted_b), .retired(retired_b)
  );

  // {mem_req,IorD,IRWrite,MemWrite,PCWrite,Branch,BranchNe,RegWrite,RegDst,MemtoReg,ALUSrcA,ALUSrcB,ALUOp,PCSrc}
  wire [16:0] ctrl_a = {mem_req_a, IorD_a, IRWrite_a, MemWrite_a, PCWrite_a, Branch_a, BranchNe_a,
                        RegWrite_a, RegDst_a, MemtoReg_a, ALUSrcA_a, ALUSrcB_a, ALUOp_a, PCSrc_a};
  wire [16:0] ctrl_b = {mem_req_b, IorD_b, IRWrite_b, MemWrite_b, PCWrite_b, Branch_b, BranchNe_b,
                        RegWrite_b, RegDst_b, MemtoReg_b, ALUSrcA_b, ALUSrcB_b, ALUOp_b, PCSrc_b};

  localparam logic [16:0] C_FW  = 17'b1_0_0_0_0_0_0_0_0_0_0_01_00_00;
  localparam logic [16:0] C_FG  = 17'b1_0_1_0_1_0_0_0_0_0_0_01_00_00;
  localparam logic [16:0] C_DEC = 17'b0_0_0_0_0_0_0_0_0_0_0_11_00_00;
  localparam logic [16:0] C_MA  = 17'b0_0_0_0_0_0_0_0_0_0_1_10_00_00;
  localparam logic [16:0] C_MR  = 17'b1_1_0_0_0_0_0_0_0_0_0_00_00_00;
  localparam logic [16:0] C_MWB = 17'b0_0_0_0_0_0_0_1_0_1_0_00_00_00;
  localparam logic [16:0] C_MW  = 17'b1_1_0_1_0_0_0_0_0_0_0_00_00_00;
  localparam logic [16:0] C_EX  = 17'b0_0_0_0_0_0_0_0_0_0_1_00_10_00;
  localparam logic [16:0] C_AWB = 17'b0_0_0_0_0_0_0_1_1_0_0_00_00_00;
  localparam logic [16:0] C_BEQ = 17'b0_0_0_0_0_1_0_0_0_0_1_00_01_01;
  localparam logic [16:0] C_BNE = 17'b0_0_0_0_0_0_1_0_0_0_1_00_01_01;
  localparam logic [16:0] C_IWB = 17'b0_0_0_0_0_0_0_1_0_0_0_00_00_00;
  localparam logic [16:0] C_J   = 17'b0_0_0_0_1_0_0_0_0_0_0_00_00_10;
  localparam logic [16:0] C_H   = 17'b0;

  typedef struct packed {
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [16:0] ctrl;
    logic [7:0]  ret;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [5:0] o, input logic r, input logic [3:0] s, input logic [16:0] c, input logic [7:0] n);
    vecs.push_back('{o, r, s, c, n});
  endtask

  task automatic cyc(input logic [5:0] o, input logic r);
    @(negedge clk);
    op = o;
    rdy = r;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rdy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    op = 6'd0;
    rdy = 1'b0;
    // add
    add(6'h00, 1, 0, C_FG, 0);   add(6'h00, 1, 1, C_DEC, 0);
    add(6'h00, 1, 6, C_EX, 0);   add(6'h00, 1, 7, C_AWB, 0);
    // lw: 3 FETCH waits, 2 MEMREAD waits
    add(6'h23, 0, 0, C_FW, 1);   add(6'h23, 0, 0, C_FW, 1);   add(6'h23, 0, 0, C_FW, 1);
    add(6'h23, 1, 0, C_FG, 1);   add(6'h23, 1, 1, C_DEC, 1);  add(6'h23, 0, 2, C_MA, 1);
    add(6'h23, 0, 3, C_MR, 1);   add(6'h23, 0, 3, C_MR, 1);   add(6'h23, 1, 3, C_MR, 1);
    add(6'h23, 1, 4, C_MWB, 1);
    // sw with one wait; MemWrite must be gone in the following FETCH
    add(6'h2b, 1, 0, C_FG, 2);   add(6'h2b, 1, 1, C_DEC, 2);  add(6'h2b, 1, 2, C_MA, 2);
    add(6'h2b, 0, 5, C_MW, 2);   add(6'h2b, 1, 5, C_MW, 2);
    // beq, bne
    add(6'h04, 1, 0, C_FG, 3);   add(6'h04, 1, 1, C_DEC, 3);  add(6'h04, 1, 8, C_BEQ, 3);
    add(6'h05, 1, 0, C_FG, 4);   add(6'h05, 1, 1, C_DEC, 4);  add(6'h05, 1, 8, C_BNE, 4);
    // addi, j
    add(6'h08, 1, 0, C_FG, 5);   add(6'h08, 1, 1, C_DEC, 5);  add(6'h08, 0, 9, C_MA, 5);
    add(6'h08, 0, 10, C_IWB, 5);
    add(6'h02, 1, 0, C_FG, 6);   add(6'h02, 1, 1, C_DEC, 6);  add(6'h02, 1, 11, C_J, 6);
    // illegal opcode halts
    add(6'h3f, 1, 0, C_FG, 7);   add(6'h3f, 1, 1, C_DEC, 7);  add(6'h3f, 1, 15, C_H, 7);
    add(6'h00, 1, 15, C_H, 7);

    #2;
    chk("reset_state", 32'(state_a), 32'd0);
    chk("reset_retired", retired_a, 32'd0);
    chk("reset_halted", 32'(halted_a), 32'd0);
    chk("reset_ctrl", 32'(ctrl_a), 32'(C_FW));
    @(negedge clk);
    rst_n = 1'b1;
    foreach (vecs[i]) begin
      cyc(vecs[i].op, vecs[i].rdy);
      #1;
      chk($sformatf("vec%0d_state", i), 32'(state_a), 32'(vecs[i].st));
      chk($sformatf("vec%0d_ctrl", i), 32'(ctrl_a), 32'(vecs[i].ctrl));
      chk($sformatf("vec%0d_retired", i), retired_a, 32'(vecs[i].ret));
      chk($sformatf("vec%0d_halted", i), 32'(halted_a), 32'(vecs[i].st == 4'd15));
    end

    // async reset while sw waits in MEMWRITE
    do_reset();
    repeat (4) cyc(6'h00, 1'b1);
    repeat (3) cyc(6'h2b, 1'b1);
    cyc(6'h2b, 1'b0);
    #1;
    chk("sw_wait_state", 32'(state_a), 32'd5);
    chk("sw_wait_memwrite", 32'(MemWrite_a), 32'd1);
    chk("sw_wait_retired", retired_a, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", 32'(state_a), 32'd0);
    chk("async_rst_memwrite", 32'(MemWrite_a), 32'd0);
    chk("async_rst_retired", retired_a, 32'd0);
    chk("async_rst_memreq", 32'(mem_req_a), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // bne disabled on dut_b: DECODE then sticky HALT
    do_reset();
    repeat (4) cyc(6'h00, 1'b1);
    cyc(6'h05, 1'b1);
    cyc(6'h05, 1'b1);
    #1;
    chk("nobne_decode", 32'(state_b), 32'd1);
    for (int i = 0; i < 20; i++) begin
      cyc(6'h05, 1'(i & 1));
      #1;
      chk("nobne_halted", 32'(halted_b), 32'd1);
      chk("nobne_state", 32'(state_b), 32'd15);
      chk("nobne_ctrl", 32'(ctrl_b), 32'(C_H));
      chk("nobne_retired", 32'(retired_b), 32'd1);
    end

    // 16 jumps on the 4-bit counter: saturate at 15
    do_reset();
    for (int k = 0; k < 16; k++) begin
      cyc(6'h02, 1'b1);
      #1;
      chk("jsat_retired", 32'(retired_b), (k < 15) ? 32'(k) : 32'd15);
      cyc(6'h02, 1'b1);
      cyc(6'h02, 1'b1);
      #1;
      chk("jsat_state", 32'(state_b), 32'd11);
      chk("jsat_pcsrc", 32'(PCSrc_b), 32'd2);
      chk("jsat_pcwrite", 32'(PCWrite_b), 32'd1);
    end
    cyc(6'h02, 1'b0);
    #1;
    chk("jsat_final", 32'(retired_b), 32'd15);
    chk("jsat_final_state", 32'(state_b), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
